// File: rtl/mc_datapath_pkg.sv
// mc_datapath_pkg: shared encodings for the multicycle MIPS controller and datapath.
//   - ALUIn2Sel, PCSel and ALUop select codes
//   - opcode and funct constants
//   - ALU control codes and the ALUop/funct decode
//   - immediate sign-extension helper
package mc_datapath_pkg;

  localparam int DATA_W = 32;

  // ALU source B select
  localparam logic [1:0] SRC2_B       = 2'b00;
  localparam logic [1:0] SRC2_FOUR    = 2'b01;
  localparam logic [1:0] SRC2_IMM     = 2'b10;
  localparam logic [1:0] SRC2_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [1:0] PCSRC_ALU_ALT = 2'b11;

  // ALUop from the controller
  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ADD_ALT = 2'b11;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct field
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_SLT  = 3'd4,
    ALU_ZERO = 3'd5
  } alu_ctl_t;

  // Unknown/X selects fall into the default arms, which give code 0 behaviour.
  function automatic alu_ctl_t alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
    alu_ctl_t ctl;
    case (aluop)
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (fn)
          FN_ADD:  ctl = ALU_ADD;
          FN_SUB:  ctl = ALU_SUB;
          FN_AND:  ctl = ALU_AND;
          FN_OR:   ctl = ALU_OR;
          FN_SLT:  ctl = ALU_SLT;
          default: ctl = ALU_ZERO;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32 x 32-bit register file, two asynchronous read ports and one
// synchronous write port. Register $0 always reads zero and ignores writes.
// A read of the register being written in the same cycle returns the old value.
// Ports:
//   CLK        clock
//   rst        synchronous active-high reset, clears every entry
//   ra1, ra2   read addresses;  rd1, rd2 read data
//   we, wa, wd write enable, write address, write data
module mc_regfile
  import mc_datapath_pkg::*;
(
  input  logic              CLK,
  input  logic              rst,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS datapath driven by the main controller's control word.
// Holds PC, IR, DR, A, B, ALUOut, the register file and the ALU with its decode,
// and returns op/funct/zero to the controller. Drives one unified memory port
// (combinational read, synchronous write inside the memory).
// Ports:
//   CLK, rst                 clock, synchronous active-high reset
//   IDSel                    memory address: 0=PC, 1=ALUOut
//   MWE                      memory write request (mem_we = MWE & ~rst)
//   IRWE                     IR load from mem_rdata
//   RFDSel                   RF destination: 0=rt, 1=rd
//   MtoRFSel                 RF write data: 0=ALUOut, 1=DR
//   RFWE                     RF write enable
//   ALUIn1Sel                ALU A: 0=PC, 1=A
//   ALUIn2Sel                ALU B: B / 4 / sext(imm) / sext(imm)<<2
//   ALUop                    add / sub / funct decode / add
//   PCSel                    PC source: ALU / ALUOut / jump target / ALU
//   Branch, PCWE             conditional (on zero) and unconditional PC write
//   mem_rdata                memory read data
//   mem_addr, mem_wdata, mem_we  memory port
//   op, funct, zero          status back to the controller
//   pc                       current PC
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        IDSel,
  input  logic        MWE,
  input  logic        IRWE,
  input  logic        RFDSel,
  input  logic        MtoRFSel,
  input  logic        RFWE,
  input  logic        ALUIn1Sel,
  input  logic [1:0]  ALUIn2Sel,
  input  logic [1:0]  ALUop,
  input  logic [1:0]  PCSel,
  input  logic        Branch,
  input  logic        PCWE,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        zero,
  output logic [31:0] pc
);

  // ALU: 32-bit wrap-around; slt compares as signed two's complement.
  function automatic logic [DATA_W-1:0] alu_compute(input alu_ctl_t ctl,
                                                    input logic [DATA_W-1:0] x,
                                                    input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] sx;
    logic signed [DATA_W-1:0] sy;
    logic [DATA_W-1:0]        r;
    sx = x;
    sy = y;
    case (ctl)
      ALU_ADD: r = x + y;
      ALU_SUB: r = x - y;
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_SLT: r = (sx < sy) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] pc_p0;
  logic [DATA_W-1:0] ir_p0;
  logic [DATA_W-1:0] dr_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [DATA_W-1:0] aluout_p2;

  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sx;

  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [4:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  alu_ctl_t          alu_ctl;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] pc_next;
  logic              pc_we;

  assign rs     = ir_p0[25:21];
  assign rt     = ir_p0[20:16];
  assign rd     = ir_p0[15:11];
  assign imm    = ir_p0[15:0];
  assign imm_sx = sext16(imm);

  mc_regfile u_regfile (
    .CLK (CLK),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (RFWE),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

  // Select muxes use case statements so an X select lands on the code-0 arm.
  always_comb begin
    rf_wa = rt;
    case (RFDSel)
      1'b1:    rf_wa = rd;
      default: rf_wa = rt;
    endcase

    rf_wd = aluout_p2;
    case (MtoRFSel)
      1'b1:    rf_wd = dr_p1;
      default: rf_wd = aluout_p2;
    endcase

    alu_a = pc_p0;
    case (ALUIn1Sel)
      1'b1:    alu_a = a_p1;
      default: alu_a = pc_p0;
    endcase

    alu_b = b_p1;
    case (ALUIn2Sel)
      SRC2_FOUR:    alu_b = 32'd4;
      SRC2_IMM:     alu_b = imm_sx;
      SRC2_IMM_SH2: alu_b = {imm_sx[DATA_W-3:0], 2'b00};
      default:      alu_b = b_p1;
    endcase

    mem_addr = pc_p0;
    case (IDSel)
      1'b1:    mem_addr = aluout_p2;
      default: mem_addr = pc_p0;
    endcase
  end

  assign alu_ctl = alu_decode(ALUop, ir_p0[5:0]);
  assign alu_y   = alu_compute(alu_ctl, alu_a, alu_b);
  assign zero    = (alu_y == '0);

  // Jump target uses the IR currently held, not one being loaded this cycle.
  always_comb begin
    pc_next = alu_y;
    case (PCSel)
      PCSRC_ALUOUT: pc_next = aluout_p2;
      PCSRC_JUMP:   pc_next = {pc_p0[31:28], ir_p0[25:0], 2'b00};
      default:      pc_next = alu_y;
    endcase
  end

  assign pc_we = PCWE | (Branch & zero);

  // Architectural state: PC and IR
  always_ff @(posedge CLK) begin
    if (rst) begin
      pc_p0 <= RESET_PC;
      ir_p0 <= '0;
    end else begin
      if (pc_we) pc_p0 <= pc_next;
      if (IRWE)  ir_p0 <= mem_rdata;
    end
  end

  // Operand stage: DR, A, B load every cycle
  always_ff @(posedge CLK) begin
    if (rst) begin
      dr_p1 <= '0;
      a_p1  <= '0;
      b_p1  <= '0;
    end else begin
      dr_p1 <= mem_rdata;
      a_p1  <= rf_rd1;
      b_p1  <= rf_rd2;
    end
  end

  // Result stage: ALUOut loads every cycle
  always_ff @(posedge CLK) begin
    if (rst) begin
      aluout_p2 <= '0;
    end else begin
      aluout_p2 <= alu_y;
    end
  end

  assign mem_wdata = b_p1;
  assign mem_we    = MWE & ~rst;
  assign op        = ir_p0[31:26];
  assign funct     = ir_p0[5:0];
  assign pc        = pc_p0;

endmodule
